// File: rtl/data_sram_bridge.sv
// Data-side adapter: MEM-stage single-cycle request -> SRAM-like split handshake, one access
// in flight. Define DBRIDGE_POSTED_WRITE_EN to release the stall on stores at addr_ok.
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byteenable,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic [31:0] mem_rdata,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok
);

`ifdef DBRIDGE_POSTED_WRITE_EN
    localparam logic PostedEn = 1'b1;
`else
    localparam logic PostedEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StCancel} state_e;

    state_e      state_q, state_d;
    logic        wr_pending_q, wr_pending_d;
    logic        data_wr_q, data_wr_d;
    logic [1:0]  data_size_q, data_size_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [3:0]  data_wstrb_q, data_wstrb_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        req_new;
    logic        can_issue;
    logic        posted;
    logic [1:0]  be_size;
    logic [1:0]  be_off;
    logic        unused_addr_lsb;

    assign req_new         = (mem_read | mem_write) & ~flush;
    assign posted          = PostedEn & data_wr_q;
    // A data_ok seen this cycle retires the posted write, so the next request may latch now.
    assign can_issue       = ~wr_pending_q | data_data_ok;
    assign unused_addr_lsb = ^mem_addr[1:0];

    always_comb begin
        be_size = 2'd2;
        be_off  = 2'd0;
        case (mem_byteenable)
            4'b0001: begin be_size = 2'd0; be_off = 2'd0; end
            4'b0010: begin be_size = 2'd0; be_off = 2'd1; end
            4'b0100: begin be_size = 2'd0; be_off = 2'd2; end
            4'b1000: begin be_size = 2'd0; be_off = 2'd3; end
            4'b0011: begin be_size = 2'd1; be_off = 2'd0; end
            4'b1100: begin be_size = 2'd1; be_off = 2'd2; end
            4'b1110: begin be_size = 2'd2; be_off = 2'd1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_pending_d = wr_pending_q;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wstrb_d = data_wstrb_q;
        mem_rdata_d  = mem_rdata_q;

        if (wr_pending_q && data_data_ok) begin
            wr_pending_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (req_new && can_issue) begin
                    state_d      = StReq;
                    data_wr_d    = mem_write;
                    data_size_d  = be_size;
                    data_addr_d  = {mem_addr[31:2], be_off};
                    data_wdata_d = mem_wdata;
                    data_wstrb_d = mem_write ? mem_byteenable : 4'b0000;
                end
            end
            StReq: begin
                // Once accepted, the access must be drained even if the instruction is flushed.
                if (data_addr_ok) begin
                    if (posted) begin
                        wr_pending_d = 1'b1;
                        state_d      = flush ? StIdle : StDone;
                    end else begin
                        state_d = flush ? StCancel : StWait;
                    end
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (data_data_ok) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StDone;
                        mem_rdata_d = data_rdata;
                    end
                end else if (flush) begin
                    state_d = StCancel;
                end
            end
            StDone: begin
                if (!pipe_stall || flush) begin
                    state_d = StIdle;
                end
            end
            StCancel: begin
                if (data_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_pending_q <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            data_wstrb_q <= 4'd0;
            mem_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            wr_pending_q <= wr_pending_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_wstrb_q <= data_wstrb_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign data_req   = (state_q == StReq);
    assign stall_req  = ((state_q == StIdle) & req_new) | (state_q == StReq) |
                        (state_q == StWait) | ((state_q == StCancel) & req_new);
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign data_wstrb = data_wstrb_q;
    assign mem_rdata  = mem_rdata_q;

endmodule
